// File: rtl/acc_requant_pkg.sv
// Shared MHA width definitions so accumulator producers and the requantizer
// derive identical datapath widths from the same activation width and depth.
package acc_requant_pkg;

  localparam int def_bit_width = 8;
  localparam int def_depth     = 4;
  localparam int def_cnt_width = 16;

  function automatic int mul_w(input int bw);
    return 2 * bw;
  endfunction

  function automatic int acc_w(input int bw, input int dp);
    return mul_w(bw) + dp - 1;
  endfunction

  function automatic int shift_w(input int aw);
    return $clog2(aw + 1);
  endfunction

  localparam int def_mul_width = mul_w(def_bit_width);
  localparam int def_acc_width = acc_w(def_bit_width, def_depth);
  localparam int def_sw        = shift_w(def_acc_width);

endpackage

// File: rtl/acc_requant_if.sv
// Valid/ready streaming bus of the requantizer plus its saturation counter
// sideband; master is the surrounding datapath, slave is the block.
interface acc_requant_if
  import acc_requant_pkg::*;
#(
  parameter int bit_width = def_bit_width,
  parameter int acc_width = def_acc_width,
  parameter int sw        = def_sw,
  parameter int cnt_width = def_cnt_width
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [acc_width-1:0] in_data;
  logic [sw-1:0]        in_shift;
  logic                 out_valid;
  logic                 out_ready;
  logic [bit_width-1:0] out_data;
  logic                 out_sat;
  logic                 sat_clr;
  logic [cnt_width-1:0] sat_count;

  modport master (
    output in_valid, in_data, in_shift, out_ready, sat_clr,
    input  in_ready, out_valid, out_data, out_sat, sat_count
  );

  modport slave (
    input  in_valid, in_data, in_shift, out_ready, sat_clr,
    output in_ready, out_valid, out_data, out_sat, sat_count
  );

endinterface

// File: rtl/acc_requant_round_shift_sat.sv
// Combinational round-half-up right shift of an unsigned accumulator followed
// by saturation to activation width.
module round_shift_sat
  import acc_requant_pkg::*;
#(
  parameter int bit_width = def_bit_width,
  parameter int acc_width = def_acc_width,
  parameter int sw        = def_sw
) (
  input  logic [acc_width-1:0] acc,
  input  logic [sw-1:0]        shift,
  output logic [bit_width-1:0] data,
  output logic                 sat
);

  localparam logic [acc_width:0] zero_w = {(acc_width + 1){1'b0}};
  localparam logic [acc_width:0] one_w  = {{acc_width{1'b0}}, 1'b1};

  logic        [acc_width:0] bias_s;
  logic        [acc_width:0] sum_s;
  logic        [acc_width:0] quot_s;
  logic                      too_far_s;

  // Add half of the discarded LSB weight, truncate, then clip to activation range.
  always_comb begin
    too_far_s = ({{(32 - sw){1'b0}}, shift} > 32'(acc_width));
    bias_s    = zero_w;
    quot_s    = zero_w;
    if (shift == {sw{1'b0}}) begin
      bias_s = zero_w;
    end else if (too_far_s) begin
      bias_s = zero_w;
    end else begin
      bias_s = one_w << (shift - {{(sw - 1){1'b0}}, 1'b1});
    end
    // The extra top bit keeps the rounding carry; no overflow is possible.
    sum_s = {1'b0, acc} + bias_s;
    if (too_far_s) begin
      quot_s = zero_w;
    end else begin
      quot_s = sum_s >> shift;
    end
    sat  = |quot_s[acc_width:bit_width];
    if (sat) begin
      data = {bit_width{1'b1}};
    end else begin
      data = quot_s[bit_width-1:0];
    end
  end

endmodule

// File: rtl/acc_requant.sv
// Two-stage requantizer with full backpressure: stage 1 registers the rounded
// and saturated result, stage 2 is the output register; counts clipped beats.
module acc_requant
  import acc_requant_pkg::*;
#(
  parameter int bit_width = def_bit_width,
  parameter int acc_width = def_acc_width,
  parameter int sw        = def_sw,
  parameter int cnt_width = def_cnt_width
) (
  input  logic          clk,
  input  logic          rst,
  acc_requant_if.slave  bus
);

  localparam logic [cnt_width-1:0] cnt_zero = {cnt_width{1'b0}};
  localparam logic [cnt_width-1:0] cnt_one  = {{(cnt_width - 1){1'b0}}, 1'b1};
  localparam logic [cnt_width-1:0] cnt_max  = {cnt_width{1'b1}};

  logic                 s1_valid_r;
  logic [bit_width-1:0] s1_data_r;
  logic                 s1_sat_r;
  logic                 s2_valid_r;
  logic [bit_width-1:0] s2_data_r;
  logic                 s2_sat_r;
  logic [cnt_width-1:0] sat_count_r;
  logic [bit_width-1:0] rss_data_s;
  logic                 rss_sat_s;
  logic                 s1_adv_s;
  logic                 s2_adv_s;
  logic                 deliver_sat_s;

  round_shift_sat #(
    .bit_width (bit_width),
    .acc_width (acc_width),
    .sw        (sw)
  ) u_rss (
    .acc   (bus.in_data),
    .shift (bus.in_shift),
    .data  (rss_data_s),
    .sat   (rss_sat_s)
  );

  assign s2_adv_s      = !s2_valid_r || bus.out_ready;
  assign s1_adv_s      = !s1_valid_r || s2_adv_s;
  assign deliver_sat_s = s2_valid_r && bus.out_ready && s2_sat_r;

  assign bus.in_ready  = s1_adv_s;
  assign bus.out_valid = s2_valid_r;
  assign bus.out_data  = s2_data_r;
  assign bus.out_sat   = s2_sat_r;
  assign bus.sat_count = sat_count_r;

  // Stage 1: capture the requantized beat whenever the slot is free or draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= {bit_width{1'b0}};
      s1_sat_r   <= 1'b0;
    end else if (s1_adv_s) begin
      s1_valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        s1_data_r <= rss_data_s;
        s1_sat_r  <= rss_sat_s;
      end
    end
  end

  // Stage 2: output register, frozen while downstream stalls a valid beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      s2_data_r  <= {bit_width{1'b0}};
      s2_sat_r   <= 1'b0;
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_data_r <= s1_data_r;
        s2_sat_r  <= s1_sat_r;
      end
    end
  end

  // Saturation counter: clear wins over increment, sticks at all ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count_r <= cnt_zero;
    end else if (bus.sat_clr) begin
      sat_count_r <= cnt_zero;
    end else if (deliver_sat_s && (sat_count_r != cnt_max)) begin
      sat_count_r <= sat_count_r + cnt_one;
    end
  end

endmodule
